// File: rtl/relu_maxpool_2d_pkg.sv
// Shared LeNet layer constants for the ReLU + 2x2 max-pool stage.
// Holds the default sample width and the feature-map sizes for the
// C1 (28x28 -> 14x14) and C3 (10x10 -> 5x5) pooling layers, plus the
// helper that derives a pooled dimension from an input dimension.
package relu_maxpool_2d_pkg;

  localparam int LENET_DATA_WIDTH = 12;

  localparam int C1_IN_WIDTH   = 28;
  localparam int C1_IN_HEIGTH  = 28;
  localparam int C1_OUT_WIDTH  = 14;
  localparam int C1_OUT_HEIGTH = 14;

  localparam int C3_IN_WIDTH   = 10;
  localparam int C3_IN_HEIGTH  = 10;
  localparam int C3_OUT_WIDTH  = 5;
  localparam int C3_OUT_HEIGTH = 5;

  // 2x2 pooling with stride 2 halves each dimension.
  function automatic int pooled_dim(input int in_dim);
    return in_dim / 2;
  endfunction

endpackage

// File: rtl/relu_maxpool_2d_max2_cell.sv
// max2_cell: combinational signed two-input maximum.
// Ports:
//   a, b : signed operands, DATA_WIDTH bits
//   y    : the larger of a and b (signed compare)
module max2_cell #(
  parameter int DATA_WIDTH = 12
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);

  // Signed select of the larger operand; ties return a.
  always_comb begin
    y = a;
    if (b > a) begin
      y = b;
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/relu_maxpool_2d.sv
// relu_maxpool_2d: ReLU followed by 2x2 stride-2 max pooling on a raster
// stream of signed convolution results. One instance per output feature map,
// placed directly after the 25-tap convolution adder tree.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data holds a sample this cycle
//   in_data   : signed sample, row-major raster order
//   out_valid : registered, one-cycle pulse per pooled sample
//   out_data  : registered pooled sample (always >= 0), held between pulses
//   out_last  : registered, marks the final pooled sample of a frame
// Even rows fold column pairs into a half-width row buffer; odd rows fold
// their column pairs against the buffer entry and emit on each odd column.
module relu_maxpool_2d
  import relu_maxpool_2d_pkg::*;
#(
  parameter int DATA_WIDTH = LENET_DATA_WIDTH,
  parameter int IN_WIDTH   = C1_IN_WIDTH,
  parameter int IN_HEIGTH  = C1_IN_HEIGTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int OUT_WIDTH  = pooled_dim(IN_WIDTH);
  localparam int OUT_HEIGTH = pooled_dim(IN_HEIGTH);
  localparam int COL_W = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W = (IN_HEIGTH > 2) ? $clog2(IN_HEIGTH) : 1;
  localparam int IDX_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGTH - 1);

  logic [COL_W-1:0]              col_r;
  logic [ROW_W-1:0]              row_r;
  logic signed [DATA_WIDTH-1:0]  hreg_r;
  logic signed [DATA_WIDTH-1:0]  rowbuf_r [OUT_WIDTH];

  logic                          col_odd_s;
  logic                          row_odd_s;
  logic                          col_wrap_s;
  logic                          row_wrap_s;
  logic                          emit_s;
  logic [IDX_W-1:0]              idx_s;
  logic signed [DATA_WIDTH-1:0]  relu_s;
  logic signed [DATA_WIDTH-1:0]  cmp_a_s;
  logic signed [DATA_WIDTH-1:0]  max_s;

  // Position decode, ReLU and compare-operand selection.
  always_comb begin
    col_odd_s  = col_r[0];
    row_odd_s  = row_r[0];
    col_wrap_s = (col_r == COL_LAST);
    row_wrap_s = (row_r == ROW_LAST);
    idx_s      = IDX_W'(col_r >> 1);
    emit_s     = in_valid & row_odd_s & col_odd_s;
    relu_s     = '0;
    if (in_data[DATA_WIDTH-1]) begin
      relu_s = '0;
    end else begin
      relu_s = in_data;
    end
    // Only the odd-row/even-column step compares against the buffer
    // (vertical fold); every other compare is against the horizontal reg.
    cmp_a_s = hreg_r;
    if (row_odd_s && !col_odd_s) begin
      cmp_a_s = rowbuf_r[idx_s];
    end else begin
      cmp_a_s = hreg_r;
    end
  end

  // Single shared comparator for horizontal and vertical folds.
  max2_cell #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max2 (
    .a (cmp_a_s),
    .b (relu_s),
    .y (max_s)
  );

  // Raster position counters; they advance only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if (in_valid) begin
      if (col_wrap_s) begin
        col_r <= '0;
        if (row_wrap_s) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + ROW_W'(1);
        end
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Horizontal register: first sample of each column pair (even column).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hreg_r <= '0;
    end else if (in_valid && !col_odd_s) begin
      if (row_odd_s) begin
        hreg_r <= max_s;
      end else begin
        hreg_r <= relu_s;
      end
    end
  end

  // Row buffer: horizontal max of each even-row pair; always written on an
  // even row before the following odd row reads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && !row_odd_s && col_odd_s) begin
      rowbuf_r[idx_s] <= max_s;
    end
  end

  // Registered output stage: one-cycle pulse per pooled sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= emit_s;
      out_last  <= emit_s & row_wrap_s & col_wrap_s;
      if (emit_s) begin
        out_data <= max_s;
      end
    end
  end

  // Pooled height is implied by the counters; kept for readability.
  logic [31:0] unused_out_heigth_s;
  assign unused_out_heigth_s = 32'(OUT_HEIGTH);

endmodule

// File: tb/tb_relu_maxpool_2d.sv
// Self-checking bench for relu_maxpool_2d: a 28x28 instance and a 10x10
// instance. The stimulus process keeps a full-frame reference model, pushes
// the expected pooled value when it sends each odd-row/odd-column sample,
// and per-instance monitors pop and compare whenever out_valid is seen.
module tb_relu_maxpool_2d;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               v28, v10;
  logic signed [11:0] d28, d10;
  logic               ov28, ov10, ol28, ol10;
  logic signed [11:0] od28, od10;

  int   errors = 0;
  int   checks = 0;
  int   n28 = 0, l28 = 0, n10 = 0, l10 = 0;
  exp_t q28[$];
  exp_t q10[$];
  exp_t e28, e10;

  int   fr[2][28][28];
  int   mrow[2];
  int   mcol[2];

  relu_maxpool_2d dut28 (
    .clk (clk), .rst_n (rst_n), .in_valid (v28), .in_data (d28),
    .out_valid (ov28), .out_data (od28), .out_last (ol28)
  );

  relu_maxpool_2d #(.DATA_WIDTH(12), .IN_WIDTH(10), .IN_HEIGTH(10)) dut10 (
    .clk (clk), .rst_n (rst_n), .in_valid (v10), .in_data (d10),
    .out_valid (ov10), .out_data (od10), .out_last (ol10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Stimulus patterns: 0 const -5, 1 ramp, 2 corner block, 3/4 mixed signs.
  function automatic int pat(input int kind, input int r, input int c);
    int v;
    case (kind)
      0: v = -5;
      1: v = r * 28 + c;
      2: begin
        if (r == 0 && c == 0)      v = -3;
        else if (r == 0 && c == 1) v = 7;
        else if (r == 1 && c == 0) v = 100;
        else if (r == 1 && c == 1) v = -2048;
        else                       v = ((r * c + 3 * r) % 50) - 25;
      end
      3: v = (((r * 10 + c) * 7) % 61) - 30;
      default: v = 2000 - (r * 10 + c) * 37;
    endcase
    return v;
  endfunction

  // Drive one cycle; on a valid sample update the model and, on an
  // odd-row/odd-column sample, push the expected pooled output.
  task automatic send(input int sel, input bit v, input int val);
    int w, r, c;
    exp_t e;
    w = (sel == 0) ? 28 : 10;
    if (sel == 0) begin v28 = v; d28 = 12'(val); end
    else          begin v10 = v; d10 = 12'(val); end
    if (v) begin
      r = mrow[sel];
      c = mcol[sel];
      fr[sel][r][c] = relu(val);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.data = max4(fr[sel][r-1][c-1], fr[sel][r-1][c], fr[sel][r][c-1], fr[sel][r][c]);
        e.last = (r == w - 1) && (c == w - 1);
        if (sel == 0) q28.push_back(e);
        else          q10.push_back(e);
      end
      if (c == w - 1) begin
        mcol[sel] = 0;
        mrow[sel] = (r == w - 1) ? 0 : r + 1;
      end else begin
        mcol[sel] = c + 1;
      end
    end
    @(posedge clk);
    #1;
    v28 = 1'b0;
    v10 = 1'b0;
  endtask

  // Send up to 'limit' samples of a frame, optionally with random gaps.
  task automatic run_frame(input int sel, input int kind, input bit gaps, input int limit);
    int w, sent;
    w = (sel == 0) ? 28 : 10;
    sent = 0;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (sent < limit) begin
          if (gaps && ($urandom_range(0, 1) == 1)) begin
            repeat ($urandom_range(1, 2)) send(sel, 1'b0, 0);
          end
          send(sel, 1'b1, pat(kind, r, c));
          sent++;
          if (sel == 0 && kind == 1 && r == 1 && c == 1) begin
            chk("ramp_first_valid", int'(ov28), 1);
            chk("ramp_first_data", int'(od28), 29);
          end
          if (sel == 0 && kind == 1 && r == 1 && c == 3) begin
            chk("ramp_second_data", int'(od28), 31);
          end
          if (sel == 0 && kind == 2 && r == 1 && c == 1) begin
            chk("block_first_data", int'(od28), 100);
          end
        end
      end
    end
  endtask

  task automatic frame_counts(input string name, input int dn, input int dl,
                              input int exp_n, input int exp_l);
    chk({name, "_outputs"}, dn, exp_n);
    chk({name, "_lasts"}, dl, exp_l);
  endtask

  // 28x28 monitor.
  always @(negedge clk) begin
    if (ov28) begin
      n28++;
      if (ol28) l28++;
      checks++;
      if (q28.size() == 0) begin
        errors++;
        $display("FAIL out28_unexpected: got data %0d last %0d, expected no output", od28, ol28);
      end else begin
        e28 = q28.pop_front();
        if (od28 !== e28.data || ol28 !== e28.last) begin
          errors++;
          $display("FAIL out28_sample: got data %0d last %0d expected data %0d last %0d",
                   od28, ol28, e28.data, e28.last);
        end
      end
    end
  end

  // 10x10 monitor.
  always @(negedge clk) begin
    if (ov10) begin
      n10++;
      if (ol10) l10++;
      checks++;
      if (q10.size() == 0) begin
        errors++;
        $display("FAIL out10_unexpected: got data %0d last %0d, expected no output", od10, ol10);
      end else begin
        e10 = q10.pop_front();
        if (od10 !== e10.data || ol10 !== e10.last) begin
          errors++;
          $display("FAIL out10_sample: got data %0d last %0d expected data %0d last %0d",
                   od10, ol10, e10.data, e10.last);
        end
      end
    end
  end

  initial begin
    int bn, bl;
    rst_n = 1'b0;
    v28 = 1'b0; v10 = 1'b0; d28 = '0; d10 = '0;
    mrow[0] = 0; mcol[0] = 0; mrow[1] = 0; mcol[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid28", int'(ov28), 0);
    chk("reset_data28", int'(od28), 0);
    chk("reset_last28", int'(ol28), 0);
    chk("reset_valid10", int'(ov10), 0);
    chk("reset_data10", int'(od10), 0);
    rst_n = 1'b1;
    send(0, 1'b0, 0);

    // All -5: every pooled output is 0, last only on the 196th.
    bn = n28; bl = l28;
    run_frame(0, 0, 1'b0, 784);
    repeat (2) send(0, 1'b0, 0);
    frame_counts("neg5", n28 - bn, l28 - bl, 196, 1);

    // Ramp frame.
    bn = n28; bl = l28;
    run_frame(0, 1, 1'b0, 784);
    repeat (2) send(0, 1'b0, 0);
    frame_counts("ramp", n28 - bn, l28 - bl, 196, 1);

    // Corner block with mixed-sign filler.
    bn = n28; bl = l28;
    run_frame(0, 2, 1'b0, 784);
    repeat (2) send(0, 1'b0, 0);
    frame_counts("block", n28 - bn, l28 - bl, 196, 1);

    // Ramp frame with random input gaps.
    bn = n28; bl = l28;
    run_frame(0, 1, 1'b1, 784);
    repeat (2) send(0, 1'b0, 0);
    frame_counts("gaps", n28 - bn, l28 - bl, 196, 1);

    // Reset mid-frame after 400 samples, then a fresh ramp frame.
    run_frame(0, 1, 1'b0, 400);
    chk("pre_reset_data_nonzero", int'(od28 != 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", int'(ov28), 0);
    chk("async_reset_data", int'(od28), 0);
    chk("async_reset_last", int'(ol28), 0);
    chk("reset_queue_drained", q28.size(), 0);
    mrow[0] = 0; mcol[0] = 0; mrow[1] = 0; mcol[1] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bn = n28; bl = l28;
    run_frame(0, 1, 1'b0, 784);
    repeat (2) send(0, 1'b0, 0);
    frame_counts("post_reset", n28 - bn, l28 - bl, 196, 1);

    // 10x10: two back-to-back frames, no idle cycle between them.
    bn = n10; bl = l10;
    run_frame(1, 3, 1'b0, 100);
    run_frame(1, 4, 1'b0, 100);
    repeat (2) send(1, 1'b0, 0);
    frame_counts("c3_two_frames", n10 - bn, l10 - bl, 50, 2);

    chk("queue28_empty", q28.size(), 0);
    chk("queue10_empty", q10.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relu_maxpool_2d.md
RELU_MAXPOOL_2D -- requirements
Module: relu_maxpool_2d

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: signed two's-complement sample width.
REQ-002 SHALL have parameter IN_WIDTH, default 28: input feature-map columns; an even value of at least 2.
REQ-003 SHALL have parameter IN_HEIGTH, default 28: input feature-map rows; an even value of at least 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: in_data carries a valid convolution result this cycle.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, signed: convolution-plus-bias sample, raster order (row-major, column 0 first).
REQ-008 SHALL have port out_valid, input-independent output, 1: out_data is valid this cycle.
REQ-009 SHALL have port out_data, output, DATA_WIDTH, signed: pooled sample, raster order over (IN_HEIGTH/2) x (IN_WIDTH/2).
REQ-010 SHALL have port out_last, output, 1: asserted with out_valid on the final pooled sample of a frame.

Function
REQ-011 SHALL apply ReLU to every accepted sample: negative values become 0; non-negative values pass unchanged.
REQ-012 SHALL hold a column counter (0..IN_WIDTH-1) and a row counter (0..IN_HEIGTH-1), both advancing only when in_valid=1.
- Column wraps to 0 after IN_WIDTH-1 and increments the row.
- Row wraps to 0 after IN_HEIGTH-1 at column wrap (next frame).
REQ-013 SHALL accept gaps in in_valid of any length; the state SHALL be held across gaps.
REQ-014 SHALL compute results per the accepted sample's row and column parity, where r = ReLU(in_data):
- Even row, even column: horizontal register <= r.
- Even row, odd column: row buffer[col/2] <= max(horizontal register, r).
- Odd row, even column: horizontal register <= max(row buffer[col/2], r).
- Odd row, odd column: emit max(horizontal register, r).
REQ-015 SHALL provide a row buffer with IN_WIDTH/2 entries of DATA_WIDTH each.
REQ-016 SHALL register out_data, out_valid and out_last, giving exactly 1 cycle latency from the accepting edge of the odd-row, odd-column sample.
REQ-017 SHALL pulse out_valid for exactly one cycle per pooled sample and emit (IN_HEIGTH/2)*(IN_WIDTH/2) samples per frame (196 at defaults).
REQ-018 SHALL assert out_last only on the sample produced by row IN_HEIGTH-1, column IN_WIDTH-1.
REQ-019 SHALL hold out_data at its last value while out_valid=0.
REQ-020 SHALL accept a back-to-back next frame with no idle cycle; the frame wrap SHALL not lose or duplicate any output.
REQ-021 SHALL perform all comparisons signed; outputs are always >= 0.

Reset
REQ-022 SHALL, on rst_n=0, immediately clear out_valid, out_last, out_data, both counters and the horizontal register to 0.
REQ-023 SHALL leave row buffer contents unreset; they are always written before being read.
REQ-024 SHALL, after reset, treat the next accepted sample as row 0, column 0, including reset asserted mid-frame; the partial frame is discarded with no output.

Structure
REQ-025 SHALL take DATA_WIDTH, IN_WIDTH and IN_HEIGTH defaults, and the derived pooled dimensions, from a shared package of LeNet layer constants (C1: 28x28 to 14x14; C3: 10x10 to 5x5).
REQ-026 SHALL instantiate one sub-module, max2_cell: a combinational signed 2-input maximum, used for both the horizontal and vertical compares.
REQ-027 SHALL sit directly downstream of the 25-tap convolution adder tree, one instance per output feature map.

Verification
REQ-028 SHALL pass a frame of all 784 samples = -5: 196 outputs of 0, out_last on the 196th only.
REQ-029 SHALL pass a ramp in_data = row*28+col, masked to 12-bit signed: first output 29 (max of 0,1,28,29), one cycle after sample (1,1); second output 31.
REQ-030 SHALL pass a single 2x2 block {-3, 7, 100, -2048} at rows 0-1, columns 0-1: first output 100.
REQ-031 SHALL pass a full frame with in_valid toggled 1-0-0-1 randomly: the output sequence is identical to the gap-free run, and no out_valid occurs during gaps.
REQ-032 SHALL pass rst_n pulsed low at sample 400, then a fresh full ramp frame: outputs are cleared asynchronously, and exactly 196 correct outputs follow.
REQ-033 SHALL pass two back-to-back frames with parameters 10x10: 25 outputs each, out_last twice, correct values across the frame boundary.
